// File: rtl/launchpad_seq_pkg.sv
// launchpad_seq_pkg
// Shared types for the LaunchPad key-sequence recorder: the FSM state
// enum and the two-bit Mode encodings driven by the keypad controller.
// No ports; imported by launchpad_seq_recorder and its testbench.
package launchpad_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REC   = 2'd1,
    FLUSH = 2'd2,
    PLAY  = 2'd3
  } seq_state_e;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_REC   = 2'b01;
  localparam logic [1:0] MODE_PLAY  = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

endpackage

// File: rtl/seq_tick_gen.sv
// seq_tick_gen
// Divides the system clock down to a one-cycle tick every TICK_DIV cycles.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset (divider back to 0)
//   i_clr    synchronous restart: divider returns to 0, no tick this cycle
//   o_tick   one-cycle pulse when the divider reaches its terminal count
module seq_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc   = (r_cnt == CW'(TICK_DIV - 1));
  assign o_tick = w_tc && !i_clr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/launchpad_seq_recorder.sv
// launchpad_seq_recorder
// Records timed keypad note events (note code + duration in ticks) into a
// small register memory and replays them as a registered note stream.
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   Keys       button levels, lowest set index wins
//   Mode       00 idle, 01 record, 10 play, 11 clear
//   Note       registered note code, 0 = rest, k+1 = key k
//   NoteValid  a recorded entry is currently being played
//   Count      number of stored events
//   Full       Count == DEPTH
//   Busy       FSM is in PLAY
// Build option: define LAUNCHPAD_SEQ_LOOP_EN to wrap playback to entry 0
// instead of ending after the last entry.
//
// state | meaning
// IDLE  | waiting for Mode; clear acts here
// REC   | run-length tracking key code on each tick, writing finished runs
// FLUSH | one cycle: commit the pending run, then back to IDLE
// PLAY  | stepping through entries; first cycle loads entry 0
module launchpad_seq_recorder
  import launchpad_seq_pkg::*;
#(
  parameter  int KEYS     = 12,
  parameter  int DEPTH    = 16,
  parameter  int DUR_W    = 8,
  parameter  int TICK_DIV = 1000,
  localparam int NOTE_W   = $clog2(KEYS + 1),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [KEYS-1:0]   Keys,
  input  logic [1:0]        Mode,
  output logic [NOTE_W-1:0] Note,
  output logic              NoteValid,
  output logic [CNT_W-1:0]  Count,
  output logic              Full,
  output logic              Busy
);

  localparam int              AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DUR_W-1:0] DMAX = '1;

  seq_state_e        r_state;
  logic              r_play_first;
  logic [NOTE_W-1:0] r_cur;
  logic [DUR_W-1:0]  r_dur;
  logic [CNT_W-1:0]  r_count;
  logic [AW-1:0]     r_addr;
  logic [DUR_W-1:0]  r_elapsed;
  logic [NOTE_W-1:0] r_note;
  logic              r_valid;

  logic [NOTE_W-1:0] r_mem_note [DEPTH];
  logic [DUR_W-1:0]  r_mem_dur  [DEPTH];

  logic [NOTE_W-1:0] w_code;
  logic              w_tick;
  logic              w_div_clr;
  logic              w_full;
  logic              w_extend;
  logic              w_wr_en;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_addr_nxt;
  logic              w_last;
  logic              w_expire;

  always_comb begin
    w_code = '0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (Keys[i]) w_code = NOTE_W'(i + 1);
    end
  end

  // The divider is held at 0 through the first PLAY cycle too, so the first
  // entry is held for exactly dur*TICK_DIV cycles from when Note loads.
  assign w_div_clr = (r_state == IDLE) || (r_state == FLUSH) || r_play_first;

  seq_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk  (CLK),
    .i_rst_n(RST),
    .i_clr  (w_div_clr),
    .o_tick (w_tick)
  );

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_extend   = (r_cur == w_code) && (r_dur != DMAX);
  assign w_wr_addr  = r_count[AW-1:0];
  // Finished runs are written from REC on a non-extending tick, or from FLUSH.
  assign w_wr_en    = !w_full && (r_dur != '0) &&
                      (((r_state == REC) && (Mode == MODE_REC) && w_tick && !w_extend) ||
                       (r_state == FLUSH));
  assign w_addr_nxt = r_addr + AW'(1);
  assign w_last     = ((CNT_W'(r_addr) + CNT_W'(1)) == r_count);
  assign w_expire   = ((r_elapsed + DUR_W'(1)) == r_mem_dur[r_addr]);

  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_mem_note[w_wr_addr] <= r_cur;
      r_mem_dur[w_wr_addr]  <= r_dur;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_play_first <= 1'b0;
      r_cur        <= '0;
      r_dur        <= '0;
      r_count      <= '0;
      r_addr       <= '0;
      r_elapsed    <= '0;
      r_note       <= '0;
      r_valid      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          unique case (Mode)
            MODE_REC:   r_state <= REC;
            MODE_PLAY: begin
              if (r_count != '0) begin
                r_state      <= PLAY;
                r_play_first <= 1'b1;
              end
            end
            MODE_CLEAR: r_count <= '0;
            default: ;
          endcase
        end
        REC: begin
          if (Mode != MODE_REC) begin
            r_state <= FLUSH;
          end else if (w_tick) begin
            if (r_dur == '0) begin
              r_cur <= w_code;
              r_dur <= DUR_W'(1);
            end else if (w_extend) begin
              r_dur <= r_dur + DUR_W'(1);
            end else begin
              if (w_wr_en) r_count <= r_count + CNT_W'(1);
              r_cur <= w_code;
              r_dur <= DUR_W'(1);
            end
          end
        end
        FLUSH: begin
          if (w_wr_en) r_count <= r_count + CNT_W'(1);
          r_dur   <= '0;
          r_state <= IDLE;
        end
        PLAY: begin
          if (Mode != MODE_PLAY) begin
            r_state      <= IDLE;
            r_play_first <= 1'b0;
            r_note       <= '0;
            r_valid      <= 1'b0;
          end else if (r_play_first) begin
            r_play_first <= 1'b0;
            r_addr       <= '0;
            r_elapsed    <= '0;
            r_note       <= r_mem_note[0];
            r_valid      <= 1'b1;
          end else if (w_tick) begin
            if (w_expire) begin
              r_elapsed <= '0;
              if (w_last) begin
`ifdef LAUNCHPAD_SEQ_LOOP_EN
                r_addr <= '0;
                r_note <= r_mem_note[0];
`else
                r_state <= IDLE;
                r_note  <= '0;
                r_valid <= 1'b0;
`endif
              end else begin
                r_addr <= w_addr_nxt;
                r_note <= r_mem_note[w_addr_nxt];
              end
            end else begin
              r_elapsed <= r_elapsed + DUR_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Note      = r_note;
  assign NoteValid = r_valid;
  assign Count     = r_count;
  assign Full      = w_full;
  assign Busy      = (r_state == PLAY);

endmodule

// File: doc/launchpad_seq_recorder.md
# launchpad_seq_recorder

Parametrised key-sequence recorder and player for the LaunchPad keypad path. It sits between the keypad button vector and the tone generator (PianoPlay). It records timed note events (key index plus duration in ticks) into an internal event memory, then replays them as a registered note stream. It generalises the fixed 12-key / 16-entry store-and-recall path with these additions:
- configurable key count, depth and duration width;
- recorded note durations;
- appended recording and a clear mode;
- optional looping playback.

## Interface
- KEYS, 12: number of keypad buttons.
- DEPTH, 16: event memory entries.
- DUR_W, 8: duration field width; max duration DMAX = 2^DUR_W-1 ticks.
- TICK_DIV, 1000: CLK cycles per tick (≥2).
- NOTE_W, $clog2(KEYS+1): derived; note code width.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- Keys  in  KEYS  button levels; lowest set index wins.
- Mode  in  2  00 idle, 01 record, 10 play, 11 clear; sampled every cycle.
- Note  out  NOTE_W  0 = rest, k+1 = key k; registered.
- NoteValid  out  1  Note is being played.
- Count  out  $clog2(DEPTH+1)  stored events.
- Full  out  1  Count == DEPTH.
- Busy  out  1  state is PLAY.

## Operation
- Reset (RST low, async): state IDLE; Note=0, NoteValid=0, Count=0, Full=0, Busy=0; tick divider = 0; pending note/duration cleared. Memory contents are not reset.
- Key encode: code = (lowest set index)+1, or 0 if no key is pressed. Rests are recorded as ordinary events.
- Tick: a one-cycle pulse every TICK_DIV cycles. The divider restarts at 0 on every state change.
- FSM states: IDLE, REC, FLUSH, PLAY.
- IDLE transitions:
  - Mode=01 → REC.
  - Mode=10 → PLAY if Count>0, else stay IDLE.
  - Mode=11 → Count=0, Full=0 in one cycle, stay IDLE.
- REC, on each tick (dur = pending duration):
  - dur==0: cur=code, dur=1.
  - code==cur and dur<DMAX: dur++.
  - Otherwise: write (cur,dur) at address Count, Count++, then cur=code, dur=1.
  - Recording appends from the current Count; only clear mode rewinds.
- REC exit: Mode≠01 → FLUSH. FLUSH writes the pending event if dur>0, clears dur, then → IDLE. FLUSH lasts exactly one cycle.
- Full: when Count==DEPTH, writes are dropped and Count holds. Pending tracking continues and is discarded on flush.
- PLAY entry: addr=0, elapsed=0; Note=mem[0].note, NoteValid=1, Busy=1.
- PLAY, on each tick: elapsed++. When elapsed reaches the entry duration: addr++, elapsed=0, and Note loads the next entry on that same edge.
- PLAY end (addr+1==Count at expiry): Note=0, NoteValid=0 → IDLE.
- PLAY exit: Mode≠10 → IDLE next edge; Note=0, NoteValid=0. Clear mode during REC or PLAY first exits as above; the clear is acted on from IDLE.
- Memory: DEPTH × (NOTE_W+DUR_W) register array, asynchronous read, synchronous write.

## Timing
- Mode change seen at edge N → state changes at edge N.
- Play entry: Note and NoteValid are valid after edge N+1.
- An entry of duration d is held for exactly d×TICK_DIV cycles. There is no gap cycle between consecutive entries.
- First record tick occurs TICK_DIV cycles after REC entry.
- Count updates on the edge after the write tick.
- The flush write commits on the FLUSH edge; Count is final when state returns to IDLE.
- Reset mid-operation: outputs reach reset values immediately. The record in progress is lost, but memory entries below the old Count are untouched.

## Configuration
- LAUNCHPAD_SEQ_LOOP_EN defined: at PLAY end, addr wraps to 0 and playback continues. Note goes straight to mem[0].note; NoteValid stays 1 until Mode≠10.
- LAUNCHPAD_SEQ_LOOP_EN undefined: single pass, then IDLE as described in Operation.

## Structure
- Package launchpad_seq_pkg holds:
  - the state enum (IDLE, REC, FLUSH, PLAY);
  - Mode encodings MODE_IDLE, MODE_REC, MODE_PLAY, MODE_CLEAR.
- Sub-module seq_tick_gen (parameter TICK_DIV): clear input, tick output. Instantiated once.
- Key encoder, FSM and memory stay in the top module.

## Test plan
Tests 2–6 use KEYS=12, DEPTH=4, DUR_W=3, TICK_DIV=4.
1. Reset: assert RST low mid-record with Count=2 → all outputs 0 at once. After release, Mode=10 stays IDLE (Count=0).
2. Record: Mode=01; hold Keys[3] for 3 ticks, then Keys[5] for 2 ticks; Mode=00 → Count=2, mem = {(4,3),(6,2)}.
3. Saturation: record Keys[0] held for 9 ticks, then exit → entries (1,7),(1,2), Count=2.
4. Full: record 5 distinct keys of 1 tick each → Count=4, Full=1, fifth event dropped. Then Mode=11 → Count=0, Full=0.
5. Play after test 2: Mode=10 →
   - Note=4 for 12 cycles, then Note=6 for 8 cycles;
   - then NoteValid=0 and Busy=0;
   - with LAUNCHPAD_SEQ_LOOP_EN, Note=4 follows immediately.
6. Abort: Mode 10→00 during the second entry → Note=0 and NoteValid=0 next edge; Count unchanged.
